// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding, default polynomial and the
// feedback function used by both the generator and checker LFSR cores.
package prbs_pkg;

  typedef enum logic {
    SEED  = 1'b0,
    CHECK = 1'b1
  } prbs_state_e;

  localparam int          MAX_W      = 32;
  localparam int          DEF_WIDTH  = 10;
  localparam logic [31:0] DEF_TAPS   = 32'h0000_0240;

  // XOR-reduced feedback of the tapped state bits (Fibonacci form).
  function automatic logic lfsr_fb(input logic [MAX_W-1:0] state,
                                   input logic [MAX_W-1:0] taps);
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/prbs_lfsr_core.sv
// Fibonacci LFSR core: shifts in either an external bit (seeding) or its own
// feedback (free-running), and exposes the feedback as the next-bit prediction.
module prbs_lfsr_core
  import prbs_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_bit,
  input  logic             use_ext,
  input  logic             advance,
  output logic [WIDTH-1:0] state,
  output logic             pred
);

  logic ins;

  assign pred = lfsr_fb(MAX_W'(state), MAX_W'(TAPS));
  assign ins  = use_ext ? load_bit : pred;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= '0;
    end else if (advance) begin
      state <= {state[WIDTH-2:0], ins};
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-seeds from the received stream, then compares each
// bit against a free-running reference and tracks lock and error statistics.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DEF_TAPS),
  parameter int unsigned      ERR_THRESH = 4,
  parameter int               WINDOW     = 64,
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic             lock,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] state_q
);

  localparam int SEED_W = $clog2(WIDTH);
  localparam int WIN_W  = $clog2(WINDOW);
  localparam int ERR_W  = $clog2(WINDOW + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  prbs_state_e       fsm_q, fsm_d;
  logic [SEED_W-1:0] seed_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [ERR_W-1:0]  win_err;
  logic              pred;
  logic              in_check;
  logic              acc_chk;
  logic              acc_seed;
  logic              mismatch;
  logic              seed_done;
  logic              seed_ok;
  logic              thr_hit;
  logic              win_wrap;

  prbs_lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_bit (bit_in),
    .use_ext  (~in_check),
    .advance  (bit_valid),
    .state    (state_q),
    .pred     (pred)
  );

  assign in_check  = (fsm_q == CHECK);
  assign acc_chk   = bit_valid & in_check;
  assign acc_seed  = bit_valid & ~in_check;
  assign mismatch  = bit_in ^ pred;
  assign seed_done = acc_seed && (seed_cnt == SEED_W'(WIDTH - 1));
  // An all-zero seed would lock the reference at zero forever, so reject it.
  assign seed_ok   = |{state_q[WIDTH-2:0], bit_in};
  assign win_wrap  = (win_cnt == WIN_W'(WINDOW - 1));
  assign thr_hit   = (ERR_THRESH != 0) && acc_chk &&
                     ((32'(win_err) + 32'(mismatch)) >= ERR_THRESH);
  assign lock      = in_check;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q <= SEED;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      SEED:    if (seed_done && seed_ok) fsm_d = CHECK;
      CHECK:   if (thr_hit) fsm_d = SEED;
      default: fsm_d = SEED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seed_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= acc_chk & mismatch;

      if (clear) begin
        err_count <= '0;
      end else if (acc_chk && mismatch) begin
        err_count <= sat_inc(err_count);
      end

      if (acc_seed) begin
        seed_cnt <= seed_done ? '0 : seed_cnt + SEED_W'(1);
      end

      // Losing lock takes priority over the window wrap on the same bit.
      if (thr_hit) begin
        seed_cnt <= '0;
        win_cnt  <= '0;
        win_err  <= '0;
      end else if (acc_chk) begin
        if (win_wrap) begin
          win_cnt <= '0;
          win_err <= '0;
        end else begin
          win_cnt <= win_cnt + WIN_W'(1);
          win_err <= win_err + ERR_W'(mismatch);
        end
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a vector table for lock/error/clear basics
// plus hand sequences for windows, unlock, saturation and bit_valid gaps.
module tb_prbs_checker;

  localparam logic [9:0] TAPS = 10'h240;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bit_in;
  logic        bit_valid;
  logic        clear;
  logic        lock, err_pulse;
  logic [15:0] err_count;
  logic [9:0]  state_q;
  logic        lock2, err_pulse2;
  logic [3:0]  err_count2;
  logic [9:0]  state_q2;

  logic [9:0]  g;
  int          total  = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  prbs_checker u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear     (clear),
    .lock      (lock),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .state_q   (state_q)
  );

  prbs_checker #(
    .CNT_W      (4),
    .ERR_THRESH (0)
  ) u_dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear     (clear),
    .lock      (lock2),
    .err_pulse (err_pulse2),
    .err_count (err_count2),
    .state_q   (state_q2)
  );

  typedef struct {
    logic v;
    logic f;
    logic c;
    logic exp_lock;
    logic exp_pulse;
    int   exp_cnt;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic b, input logic c);
    @(negedge clk);
    bit_valid = v;
    bit_in    = b;
    clear     = c;
    @(posedge clk);
    #1;
  endtask

  // Next generator bit, optionally flipped on the line, after 0..max_gap idle cycles.
  task automatic send(input logic f, input logic c, input int max_gap);
    int   n;
    logic nb;
    n = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    nb = ^(g & TAPS);
    g  = {g[8:0], nb};
    drive(1'b1, nb ^ f, c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    clear     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int bad;
    rst_n     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    clear     = 1'b0;
    g         = 10'h001;

    // Reset state
    do_reset();
    check("rst_lock", lock, 0);
    check("rst_pulse", err_pulse, 0);
    check("rst_count", err_count, 0);
    check("rst_state", state_q, 0);
    check("rst_lock_sat", lock2, 0);

    // Vector table: lock-in, single errors, idle cycles, clear priority
    for (int i = 0; i < 9; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].v) send(tbl[i].f, tbl[i].c, 0);
      else drive(1'b0, 1'b0, tbl[i].c);
      check($sformatf("tbl%0d_lock", i), lock, tbl[i].exp_lock);
      check($sformatf("tbl%0d_pulse", i), err_pulse, tbl[i].exp_pulse);
      check($sformatf("tbl%0d_count", i), err_count, tbl[i].exp_cnt);
    end

    // Clean lock and 1000-bit run, back-to-back then with random gaps
    for (int run = 0; run < 2; run++) begin
      do_reset();
      g = 10'h001;
      for (int i = 0; i < 9; i++) send(1'b0, 1'b0, run * 3);
      check($sformatf("t1_nolock_r%0d", run), lock, 0);
      send(1'b0, 1'b0, run * 3);
      check($sformatf("t1_lock_r%0d", run), lock, 1);
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
        send(1'b0, 1'b0, run * 3);
        if (lock !== 1'b1 || err_count !== 16'd0 || err_pulse !== 1'b0) bad++;
      end
      check($sformatf("t1_clean_r%0d", run), bad, 0);
    end

    // Four errors in one window drop lock; ten clean bits relock
    for (int run = 0; run < 2; run++) begin
      do_reset();
      for (int i = 0; i < 10; i++) send(1'b0, 1'b0, run * 3);
      check($sformatf("t3_lock_r%0d", run), lock, 1);
      for (int k = 1; k <= 4; k++) begin
        for (int i = 0; i < 4; i++) send(1'b0, 1'b0, run * 3);
        send(1'b1, 1'b0, run * 3);
        check($sformatf("t3_cnt%0d_r%0d", k, run), err_count, k);
        check($sformatf("t3_pulse%0d_r%0d", k, run), err_pulse, 1);
        check($sformatf("t3_lock%0d_r%0d", k, run), lock, (k < 4) ? 1 : 0);
      end
      for (int i = 0; i < 9; i++) send(1'b0, 1'b0, run * 3);
      check($sformatf("t3_relock9_r%0d", run), lock, 0);
      send(1'b0, 1'b0, run * 3);
      check($sformatf("t3_relock10_r%0d", run), lock, 1);
      check($sformatf("t3_cnt_final_r%0d", run), err_count, 4);
    end

    // Window wrap clears win_err; threshold reached on the wrap bit unlocks
    do_reset();
    for (int i = 0; i < 10; i++) send(1'b0, 1'b0, 0);
    bad = 0;
    for (int w = 0; w < 12; w++) begin
      for (int i = 0; i < 64; i++) begin
        logic f;
        if (w < 10)       f = (i == 10 || i == 20 || i == 30);
        else if (w == 10) f = (i >= 61);
        else              f = (i < 2 || i >= 62);
        send(f, 1'b0, 0);
        if (!(w == 11 && i == 63) && lock !== 1'b1) bad++;
      end
      if (w == 9) check("t4_cnt30", err_count, 30);
    end
    check("t4_lock_held", bad, 0);
    check("t4_wrap_unlock", lock, 0);
    check("t4_cnt37", err_count, 37);

    // All-zero stream never locks
    do_reset();
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (lock !== 1'b0) bad++;
    end
    check("t5_never_lock", bad, 0);
    check("t5_count", err_count, 0);
    check("t5_state", state_q, 0);

    // Saturation, clear and reset mid-CHECK on the 4-bit, never-unlock instance
    do_reset();
    for (int i = 0; i < 10; i++) send(1'b0, 1'b0, 0);
    check("t6_lock", lock2, 1);
    for (int i = 0; i < 15; i++) send(1'b1, 1'b0, 0);
    check("t6_cnt15", err_count2, 15);
    for (int i = 0; i < 25; i++) send(1'b1, 1'b0, 0);
    check("t6_sat", err_count2, 15);
    check("t6_lock_kept", lock2, 1);
    check("t6_pulse", err_pulse2, 1);
    drive(1'b0, 1'b0, 1'b1);
    check("t6_clear", err_count2, 0);
    check("t6_pulse_idle", err_pulse2, 0);
    check("t6_lock_after_clear", lock2, 1);
    @(negedge clk);
    rst_n     = 1'b0;
    clear     = 1'b0;
    bit_valid = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_lock", lock2, 0);
    check("t6_rst_state", state_q2, 0);
    check("t6_rst_count", err_count2, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    bit_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
